// File: rtl/sequential_adder_ctrl_if.sv
// Request/result bundle for the slice-serial add/subtract sequencer.
// The master drives operands and start; the slave returns the result and status.
interface sequential_adder_ctrl_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             carryIn;
    logic             sub;
    logic [WIDTH-1:0] sum;
    logic             carryOut;
    logic             busy;
    logic             done;

    modport master (
        output start, a, b, carryIn, sub,
        input  sum, carryOut, busy, done
    );

    modport slave (
        input  start, a, b, carryIn, sub,
        output sum, carryOut, busy, done
    );
endinterface

// File: rtl/sequential_adder_ctrl.sv
// Multi-cycle add/subtract: one SLICE_W ripple slice per clock, LSB slice first,
// with the inter-slice carry held in a register. done pulses once per operation.
module sequential_adder_ctrl #(
    parameter int WIDTH   = 32,
    parameter int SLICE_W = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    sequential_adder_ctrl_if.slave bus
);
    localparam int N     = WIDTH / SLICE_W;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

    if (WIDTH % SLICE_W != 0) begin : g_width_check
        $error("WIDTH must be an integer multiple of SLICE_W");
    end

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_e;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [WIDTH-1:0]   op_a_q, op_a_d;
    logic [WIDTH-1:0]   op_b_q, op_b_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic               carry_q, carry_d;

    logic [SLICE_W-1:0] slice_a;
    logic [SLICE_W-1:0] slice_b;
    logic [SLICE_W:0]   slice_res;

    assign slice_a   = op_a_q[int'(idx_q)*SLICE_W +: SLICE_W];
    assign slice_b   = op_b_q[int'(idx_q)*SLICE_W +: SLICE_W];
    assign slice_res = {1'b0, slice_a} + {1'b0, slice_b} + {{SLICE_W{1'b0}}, carry_q};

    always_comb begin
        // NOTE: every variable gets a default first so no path through the case infers a latch.
        state_d = state_q;
        idx_d   = idx_q;
        op_a_d  = op_a_q;
        op_b_d  = op_b_q;
        sum_d   = sum_q;
        carry_d = carry_q;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    // Subtract is a + ~b + 1, so the inverted operand is latched up front.
                    op_a_d  = bus.a;
                    op_b_d  = bus.sub ? ~bus.b : bus.b;
                    carry_d = bus.sub ? 1'b1 : bus.carryIn;
                    idx_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                sum_d[int'(idx_q)*SLICE_W +: SLICE_W] = slice_res[SLICE_W-1:0];
                carry_d = slice_res[SLICE_W];
                if (idx_q == IDX_W'(N - 1)) begin
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: operand registers are cleared too, so an aborted operation leaves nothing behind.
            state_q <= IDLE;
            idx_q   <= '0;
            op_a_q  <= '0;
            op_b_q  <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            op_a_q  <= op_a_d;
            op_b_q  <= op_b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
        end
    end

    assign bus.sum      = sum_q;
    assign bus.carryOut = carry_q;
    assign bus.busy     = (state_q == RUN);
    assign bus.done     = (state_q == DONE);
endmodule

// File: tb/tb_sequential_adder_ctrl.sv
// Scoreboard bench for sequential_adder_ctrl: expected results are queued at
// stimulus time and compared whenever done pulses.
module tb_sequential_adder_ctrl;
    localparam int WIDTH = 32;
    localparam int N     = 4;

    typedef struct {
        logic [WIDTH-1:0] sum;
        logic             cout;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    sequential_adder_ctrl_if #(.WIDTH(WIDTH)) bus ();

    sequential_adder_ctrl #(.WIDTH(WIDTH), .SLICE_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int   errors = 0;
    int   checks = 0;
    exp_t sb[$];
    int   cyc = 0;
    int   accept_cnt = 0;
    int   done_cnt = 0;
    int   prev_accept_cyc = 0;
    int   last_accept_cyc = 0;
    logic prev_busy = 1'b0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, want %0h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                   input logic cin, input logic sub);
        logic [WIDTH:0] r;
        exp_t e;
        r = {1'b0, a} + {1'b0, (sub ? ~b : b)} + (WIDTH+1)'(sub ? 1'b1 : cin);
        e.sum  = r[WIDTH-1:0];
        e.cout = r[WIDTH];
        return e;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: accept detection on busy rising, scoreboard compare on done.
    always @(negedge clk) begin
        if (bus.busy && !prev_busy) begin
            accept_cnt++;
            prev_accept_cyc = last_accept_cyc;
            last_accept_cyc = cyc;
        end
        prev_busy = bus.busy;
        if (bus.done) begin
            exp_t e;
            done_cnt++;
            check("sb_has_entry", 64'(sb.size() > 0), 64'd1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("sum", 64'(bus.sum), 64'(e.sum));
                check("carryOut", 64'(bus.carryOut), 64'(e.cout));
            end
        end
    end

    task automatic run_op(input logic [WIDTH-1:0] a_v, input logic [WIDTH-1:0] b_v,
                          input logic cin_v, input logic sub_v, input bit poke_start);
        int busy_cnt = 0;
        bit seen = 0;
        @(negedge clk);
        bus.a = a_v; bus.b = b_v; bus.carryIn = cin_v; bus.sub = sub_v; bus.start = 1'b1;
        sb.push_back(model(a_v, b_v, cin_v, sub_v));
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.a = $urandom; bus.b = $urandom;
        bus.carryIn = 1'($urandom); bus.sub = 1'($urandom);
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (bus.busy) begin
                busy_cnt++;
                if (poke_start) bus.start = 1'b1;
            end
            if (bus.done) begin
                seen = 1;
                bus.start = 1'b0;
            end
        end
        check("done_seen", 64'(seen), 64'd1);
        check("busy_cycles", 64'(busy_cnt), 64'(N));
        @(negedge clk);
        check("done_one_cycle", 64'(bus.done), 64'd0);
        check("idle_after_done", 64'(bus.busy), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc0, d0, dn_seen;
        bit ok;
        bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.carryIn = 1'b0; bus.sub = 1'b0;
        #3;
        check("rst_sum", 64'(bus.sum), 64'd0);
        check("rst_carryOut", 64'(bus.carryOut), 64'd0);
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_done", 64'(bus.done), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // Basic add, with start poked during RUN to show it is not queued.
        acc0 = accept_cnt;
        run_op(32'd560000000, 32'd390000000, 1'b0, 1'b0, 1'b1);
        @(negedge clk); #1;
        check("no_reaccept", 64'(accept_cnt - acc0), 64'd1);

        run_op(32'h000000FF, 32'h00000001, 1'b0, 1'b0, 1'b0);
        run_op(32'hFFFFFFFF, 32'd1, 1'b0, 1'b0, 1'b0);
        run_op(32'hFFFFFFFE, 32'd3, 1'b0, 1'b0, 1'b0);
        run_op(32'd0, 32'd0, 1'b1, 1'b0, 1'b0);
        run_op(32'd7, 32'd5, 1'b0, 1'b1, 1'b0);
        run_op(32'd5, 32'd7, 1'b0, 1'b1, 1'b0);
        run_op(32'd7, 32'd5, 1'b1, 1'b1, 1'b0);
        run_op(32'd5, 32'd7, 1'b1, 1'b1, 1'b0);

        // Mid-RUN reset: upper bytes still hold the previous result, carry is 1.
        d0 = done_cnt;
        @(negedge clk);
        bus.a = 32'hFFFFFFFF; bus.b = 32'd1; bus.carryIn = 1'b0; bus.sub = 1'b0; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(posedge clk);
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        check("async_rst_sum", 64'(bus.sum), 64'd0);
        check("async_rst_carryOut", 64'(bus.carryOut), 64'd0);
        check("async_rst_busy", 64'(bus.busy), 64'd0);
        check("async_rst_done", 64'(bus.done), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        dn_seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.done) dn_seen++;
        end
        check("no_done_after_abort", 64'(dn_seen), 64'd0);
        check("no_done_count_after_abort", 64'(done_cnt - d0), 64'd0);
        run_op(32'd20000, 32'd30000, 1'b0, 1'b0, 1'b0);

        // Start held high across two operations; operands change after the first accept.
        acc0 = accept_cnt;
        d0 = done_cnt;
        ok = 0;
        @(negedge clk);
        bus.a = 32'd1; bus.b = 32'd2; bus.carryIn = 1'b0; bus.sub = 1'b0; bus.start = 1'b1;
        sb.push_back(model(32'd1, 32'd2, 1'b0, 1'b0));
        @(posedge clk); #1;
        bus.a = 32'd10; bus.b = 32'd20;
        sb.push_back(model(32'd10, 32'd20, 1'b0, 1'b0));
        for (int i = 0; i < 30 && !ok; i++) begin
            @(negedge clk); #1;
            if (done_cnt - d0 >= 2) ok = 1;
        end
        bus.start = 1'b0;
        check("two_dones", 64'(ok), 64'd1);
        check("accept_gap", 64'(last_accept_cyc - prev_accept_cyc), 64'd6);
        repeat (4) @(negedge clk);
        #1;
        check("two_accepts", 64'(accept_cnt - acc0), 64'd2);
        check("sb_drained", 64'(sb.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/sequential_adder_ctrl.md
# sequential_adder_ctrl

Multi-cycle 32-bit add/subtract sequencer. Operands are latched on a start request and pushed through a single narrow ripple-carry slice, one slice per clock, least-significant slice first. The carry between slices is held in a register. This trades latency for a much shorter carry chain than the full-width combinational ripple-carry adder. The block sits beside the existing adder as its area- and timing-friendly alternative and reports completion with a one-cycle done pulse.

## Interface
- WIDTH, 32, total operand/result width; must be an integer multiple of SLICE_W
- SLICE_W, 8, width of the internal ripple-carry slice processed per cycle
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  request; sampled only in IDLE
- a  input  WIDTH  operand A; sampled with start
- b  input  WIDTH  operand B; sampled with start
- carryIn  input  1  carry into bit 0 for add; ignored when sub=1
- sub  input  1  0: a+b+carryIn; 1: a-b, computed as a+~b+1
- sum  output  WIDTH  result register
- carryOut  output  1  carry out of MSB; for subtract, 1 = no borrow
- busy  output  1  high while slices are being processed (RUN)
- done  output  1  one-cycle pulse; sum/carryOut valid

## Operation
- N = WIDTH/SLICE_W slices. Slice index counter is ceil(log2(N)) bits wide, minimum 1.
- States:
  - IDLE: waits for start.
  - RUN: processes one slice per cycle.
  - DONE: pulses done for one cycle.
- IDLE, start=1:
  - latch opA=a and opB=(sub ? ~b : b)
  - carry register = (sub ? 1 : carryIn)
  - idx=0; go to RUN
- RUN, each cycle:
  - {c, s} = opA[idx slice] + opB[idx slice] + carry
  - sum[idx*SLICE_W +: SLICE_W] = s; carry = c
  - if idx==N-1, go to DONE; otherwise idx+1
- DONE: go to IDLE unconditionally.
- carryOut is driven from the carry register. It is meaningful only from the cycle done is high until the next accepted start.
- Arithmetic is modulo 2^WIDTH. No overflow flag.
- busy = (state==RUN). done = (state==DONE). Both are registered-state decodes; no combinational path from inputs.
- start while in RUN or DONE is ignored and is not queued. It must be re-asserted in IDLE.
- a, b, sub and carryIn may change freely after the accepting edge. The latched copies are used.
- Intermediate sum bits change slice by slice during RUN. The full sum is valid only when done=1.
- sum and carryOut hold their values from done until the next accepted start.
- Reset, asynchronous, any state including mid-RUN: state=IDLE, idx=0, sum=0, carryOut=0, busy=0, done=0, operand registers cleared. The in-flight operation is discarded with no done pulse.
- After rst deasserts, the first rising edge with start=1 is accepted.

## Timing
- Edge E0: start=1 sampled in IDLE; the block enters RUN, so busy=1 after E0.
- Edges E1..EN each complete slice 0..N-1.
- After edge EN: state=DONE, done=1, busy=0, and sum/carryOut final. With default parameters N=4, so done is high in the cycle after E4.
- Edge EN+1: back to IDLE, done=0. The earliest next accept is edge EN+2.
- Throughput is one operation per N+2 cycles (6 with defaults).

## Test plan
- Reset, then a=560000000, b=390000000, carryIn=0, sub=0, start held for one cycle. Required: busy high for exactly 4 cycles, then done for 1 cycle with sum=950000000 and carryOut=0. start must not be re-accepted while busy.
- Inter-slice carry, a=32'h000000FF, b=32'h00000001, carryIn=0. Required: sum=32'h00000100, carryOut=0.
- Wrap-around:
  - a=4294967295, b=1: sum=0, carryOut=1.
  - a=4294967294, b=3: sum=1, carryOut=1.
  - a=0, b=0, carryIn=1: sum=1, carryOut=0.
- Subtract:
  - sub=1, a=7, b=5: sum=2, carryOut=1.
  - sub=1, a=5, b=7: sum=32'hFFFFFFFE, carryOut=0. carryIn=1 must not change either result.
- Start held high continuously across two ops with a=1, b=2, then a/b switched to 10/20 after the first accept edge. Required:
  - first done shows sum=3
  - second accept occurs exactly 6 cycles after the first, and its done shows sum=30
  - no start accepted during RUN/DONE
- Assert rst for one cycle during RUN, after slice 1 of 4294967295+1. Required:
  - immediately (asynchronously) sum=0, carryOut=0, busy=0, done=0
  - no done pulse follows
  - a following op 20000+30000 gives sum=50000
